// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU-sharing sequencer: FSM states, ALU
// opcodes and the seven-segment hex glyph table.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_BUF  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    localparam int        NUM_REQ   = 2;
    localparam logic [4:0] SEG_DIGIT0 = 5'b00001;
    localparam logic [7:0] SEG_ZERO   = 8'b0011_1111;

    // Segment order {dp,g,f,e,d,c,b,a}, active-high; dp is never lit.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
        logic [7:0] pattern;
        case (value)
            4'h0: pattern = 8'h3F;
            4'h1: pattern = 8'h06;
            4'h2: pattern = 8'h5B;
            4'h3: pattern = 8'h4F;
            4'h4: pattern = 8'h66;
            4'h5: pattern = 8'h6D;
            4'h6: pattern = 8'h7D;
            4'h7: pattern = 8'h07;
            4'h8: pattern = 8'h7F;
            4'h9: pattern = 8'h6F;
            4'hA: pattern = 8'h77;
            4'hB: pattern = 8'h7C;
            4'hC: pattern = 8'h39;
            4'hD: pattern = 8'h5E;
            4'hE: pattern = 8'h79;
            default: pattern = 8'h71;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit value to seven-segment hex pattern.
module seg7_hex_decoder
    import alu_share_pkg::*;
(
    input  logic [3:0] value,
    output logic [7:0] pattern
);

    assign pattern = hex_to_seg(value);

endmodule

// File: rtl/alu_share_sequencer.sv
// Round-robin sequencer sharing one 2-bit four-function ALU between two
// requesters. Define ALU_SHARE_DISPLAY_EN to build the seven-segment result display.
module alu_share_sequencer
    import alu_share_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic [3:0] req_op,
    input  logic [1:0] req_cin,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [1:0] alu_s,
    output logic       alu_cin,
    input  logic [3:0] alu_result,
    output logic [1:0] rsp_valid,
    output logic [3:0] rsp_data,
    input  logic [1:0] rsp_ready,
    output logic [4:0] seg_sel,
    output logic [7:0] seg_data
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t     state;
    logic       last_grant;
    logic       owner;
    logic [3:0] settle_cnt;

    logic [1:0] grant;
    logic       sel;
    logic       accept;
    logic       capture;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] sel_op;
    logic       sel_cin;

    // On a tie the requester not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign capture   = (state == EXEC) && (settle_cnt == 4'd1);

    assign sel     = grant[1];
    assign sel_a   = sel ? req_a[3:2]  : req_a[1:0];
    assign sel_b   = sel ? req_b[3:2]  : req_b[1:0];
    assign sel_op  = sel ? req_op[3:2] : req_op[1:0];
    assign sel_cin = sel ? req_cin[1]  : req_cin[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            settle_cnt <= 4'd0;
            alu_a      <= 2'b00;
            alu_b      <= 2'b00;
            alu_s      <= 2'b00;
            alu_cin    <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_data   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        alu_s      <= sel_op;
                        alu_cin    <= sel_cin;
                        owner      <= sel;
                        last_grant <= sel;
                        settle_cnt <= SETTLE_INIT;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (capture) begin
                        rsp_data  <= alu_result;
                        rsp_valid <= owner ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // The non-owner's rsp_ready is deliberately not looked at.
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_DISPLAY_EN
    logic [7:0] seg_next;
    logic [7:0] seg_reg;

    seg7_hex_decoder u_seg7_hex_decoder (
        .value   (alu_result),
        .pattern (seg_next)
    );

    // Loads on the same edge as rsp_data, so the digit changes as rsp_valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= SEG_ZERO;
        end else if (capture) begin
            seg_reg <= seg_next;
        end
    end

    assign seg_sel  = SEG_DIGIT0;
    assign seg_data = seg_reg;
`else
    assign seg_sel  = 5'b00000;
    assign seg_data = 8'h00;
`endif

endmodule

// File: doc/alu_share_sequencer.md
# alu_share_sequencer

Sequencer and arbiter that shares the single 2-bit four-function ALU (buffer, NAND, add, multiply) between two requesters. It round-robin arbitrates requests, latches the operands and opcode, drives the ALU for a programmable settle window, captures the 4-bit result and returns it over a per-requester response handshake. The last captured result is shown on the board's seven-segment digit.

## Interface
- SETTLE_CYCLES, 1: cycles the ALU inputs are held before the result is captured; legal range 1–15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- req_valid  in  2  request strobe; bit i belongs to requester i.
- req_ready  out  2  one-hot grant/accept; at most one bit is high.
- req_a  in  4  operand A; bits [2i+1:2i] belong to requester i.
- req_b  in  4  operand B, packed like req_a.
- req_op  in  4  opcode, packed like req_a: 00 buffer, 01 NAND, 10 add, 11 multiply.
- req_cin  in  2  carry-in per requester; used by add only.
- alu_a, alu_b  out  2 each  operands to the shared ALU.
- alu_s  out  2  ALU function select, equal to the latched opcode.
- alu_cin  out  1  ALU carry-in.
- alu_result  in  4  combinational ALU result.
- rsp_valid  out  2  one-hot response strobe to the owning requester.
- rsp_data  out  4  captured result; shared by both requesters.
- rsp_ready  in  2  response accept per requester.
- seg_sel  out  5  digit select.
- seg_data  out  8  segment pattern, {dp,g,f,e,d,c,b,a}, active-high.

## Operation
- FSM states: IDLE, EXEC, RESP.
- In IDLE, req_ready[i] = grant[i]. The grant is combinational from req_valid and last_grant:
  - if exactly one bit of req_valid is set, grant goes to that requester;
  - if both are set, grant goes to the requester not served last.
- Accept happens when req_valid[i] & req_ready[i]. On accept:
  - latch a, b, op and cin of requester i, plus owner = i;
  - set last_grant = i, load settle counter = SETTLE_CYCLES, go to EXEC.
- Dropping req_valid before it is accepted is legal and commits nothing.
- In EXEC:
  - alu_* outputs present the latched values;
  - the counter decrements each cycle;
  - on the cycle the counter reaches 1, register rsp_data ← alu_result and go to RESP.
- In RESP:
  - rsp_valid[owner] = 1 until rsp_ready[owner]; on that handshake, go to IDLE.
  - rsp_ready of the non-owner is ignored.
  - No request is accepted in EXEC or RESP; req_ready = 00 there.
- Outside EXEC, the alu_* outputs hold their last values; they are only meaningful in EXEC.
- Result widths: buffer {00,a}; NAND {00,~(a&b)}; add {0,a+b+cin}; multiply a*b (0–9). The sequencer passes the ALU's 4 bits through without checking them.
- Display: whenever rsp_data is captured, the display register loads the hex pattern for the result (0–F); seg_sel = 5'b00001.
- Reset values:
  - state IDLE, last_grant = 1 (so requester 0 wins the first tie);
  - req_ready and rsp_valid = 00; rsp_data = 0; alu_a, alu_b, alu_s, alu_cin = 0;
  - seg_data = 8'b00111111 (digit 0), seg_sel = 5'b00001.
- Reset asserted mid-operation abandons the transaction; no response is issued.

## Timing
- Accept edge is t. EXEC spans t+1 … t+SETTLE_CYCLES.
- rsp_data is captured at the end of cycle t+SETTLE_CYCLES; rsp_valid is high from t+SETTLE_CYCLES+1.
- If rsp_ready is already high, RESP lasts one cycle. The next accept is possible at t+SETTLE_CYCLES+2 at the earliest.
- Throughput: one operation per SETTLE_CYCLES+2 cycles.
- seg_data updates in the same cycle rsp_valid rises.
- rsp_ready held low stalls indefinitely in RESP; requests wait.

## Configuration
- ALU_SHARE_DISPLAY_EN defined: display register and hex decoder are built as described above.
- ALU_SHARE_DISPLAY_EN not defined: seg_sel = 5'b00000 and seg_data = 8'h00 (constants); no display register is built.

## Structure
- Package alu_share_pkg holds:
  - state enum (IDLE/EXEC/RESP);
  - opcode constants OP_BUF/OP_NAND/OP_ADD/OP_MUL;
  - the 16 seven-segment hex patterns.
- Sub-module seg7_hex_decoder: 4-bit value → 8-bit pattern, combinational. It is instantiated only under ALU_SHARE_DISPLAY_EN.

## Test plan
- After reset: req_ready = 00, rsp_valid = 00, seg_data = 8'b00111111.
- Req0 op=11, a=3, b=3, rsp_ready tied 1, SETTLE_CYCLES=1 → rsp_valid = 01 two cycles after accept; rsp_data = 9; seg_data = 8'b01101111.
- Req1 op=10, a=2, b=3, cin=1 → rsp_data = 6; rsp_valid = 10; seg_data = 8'b01111101.
- Both requesters valid continuously → grants alternate 01, 10, 01, 10, starting with requester 0.
- rsp_ready low for 5 cycles during RESP → rsp_valid held, rsp_data stable, req_ready = 00 throughout; release → IDLE next cycle.
- rst_n pulsed low during EXEC with SETTLE_CYCLES=4 → all outputs return to reset values immediately; no rsp_valid appears afterward.
